dds_sweep_ctrl: RTL and testbench
=================================

DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 SHALL have parameter PHASE_INC_WIDTH, default 16: width of all frequency-word ports and registers.
REQ-002 SHALL have parameter DWELL_WIDTH, default 16: width of the dwell counter and dwell_i.
REQ-003 SHALL have port clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port start_i, input, 1: sweep start request, sampled on the clock edge.
REQ-006 SHALL have port stop_i, input, 1: sweep abort request.
REQ-007 SHALL have port mode_i, input, 1: 0 = single sweep, 1 = continuous (wrapping) sweep.
REQ-008 SHALL have ports f_start_i, f_stop_i and f_step_i, input, PHASE_INC_WIDTH each: first word, last allowed word and increment, all unsigned.
REQ-009 SHALL have port dwell_i, input, DWELL_WIDTH: extra cycles each word is held.
REQ-010 SHALL have port phase_inc_o, output, PHASE_INC_WIDTH: phase increment driven to the DDS phase_inc_i.
REQ-011 SHALL have port phase_inc_ena_o, output, 1: accumulator enable driven to the DDS phase_inc_ena_i.
REQ-012 SHALL have ports update_o, done_o and err_o, output, 1 each: single-cycle pulses for new word, sweep complete and rejected start.
REQ-013 SHALL have port busy_o, output, 1: high while a sweep is active.

Function
REQ-014 SHALL implement two states: IDLE and DWELL.
REQ-015 SHALL, in IDLE with start_i=1 and stop_i=0, validate the request: f_step_i==0 or f_start_i>f_stop_i -> err_o=1 for one cycle, stay IDLE, outputs otherwise unchanged.
REQ-016 SHALL, for a valid start at edge N, act at that same edge N:
  - capture f_stop, f_step, dwell and mode
  - set phase_inc_o=f_start_i, update_o=1, cnt=dwell_i
  - set phase_inc_ena_o=1, busy_o=1
  - enter DWELL
REQ-017 SHALL, in DWELL, do the following each edge:
  - cnt!=0: decrement cnt.
  - cnt==0: compute next = phase_inc_o + step in PHASE_INC_WIDTH+1 bits.
REQ-018 SHALL, when next<=f_stop and no carry-out, set phase_inc_o=next, pulse update_o and reload cnt=dwell; each word is thus held dwell+1 cycles.
REQ-019 SHALL, when next>f_stop or carry-out, act according to the captured mode:
  - mode=1: phase_inc_o=f_start (captured), pulse update_o, reload cnt and stay in DWELL.
  - mode=0: pulse done_o, go IDLE and deassert phase_inc_ena_o and busy_o; phase_inc_o holds its last value.
REQ-020 SHALL, on stop_i=1 in DWELL, go IDLE at that edge with phase_inc_ena_o=0 and busy_o=0, phase_inc_o held, no done_o and no update_o; stop_i has priority over a step/wrap event at the same edge.
REQ-021 SHALL ignore start_i while in DWELL, and ignore changes on the config inputs after capture.
REQ-022 SHALL ignore start_i when start_i and stop_i are both 1 in IDLE (no err_o).
REQ-023 SHALL, when f_start==f_stop, hold that single word dwell+1 cycles, then wrap (mode=1) or finish (mode=0).
REQ-024 SHALL keep update_o, done_o and err_o each high for exactly one cycle per event, and never assert done_o and update_o in the same cycle.
REQ-025 SHALL drive all outputs directly from registers.

Reset
REQ-026 SHALL, while rst_i=1, immediately and without a clock edge force:
  - state to IDLE, cnt to 0
  - phase_inc_o, phase_inc_ena_o, update_o, done_o, err_o and busy_o to 0
  - all captured config registers to 0
REQ-027 SHALL abandon any sweep in progress on reset with no done_o, and accept start_i on the first edge after rst_i falls.

Verification
REQ-028 SHALL cover single sweep: f_start=100, f_stop=130, f_step=10, dwell=2, mode=0, start at edge N ->
  - phase_inc_o = 100/110/120/130, each for 3 cycles (changing at edges N, N+3, N+6, N+9)
  - update_o pulses at those edges
  - done_o pulse after edge N+12
  - phase_inc_ena_o high exactly 12 cycles; phase_inc_o stays 130
REQ-029 SHALL cover continuous mode with the same config -> after 130 the word returns to 100 at edge N+12 with update_o, no done_o; repeats for 3 periods, then stop_i ends it with phase_inc_o held.
REQ-030 SHALL cover carry: PHASE_INC_WIDTH=16, f_start=0xFFF0, f_stop=0xFFFF, f_step=0x0010, dwell=0 -> one word 0xFFF0 for 1 cycle, then done_o; phase_inc_o is never 0x0000.
REQ-031 SHALL cover rejects: f_step=0 -> err_o for 1 cycle, busy_o stays 0; f_start=200 with f_stop=100 -> err_o; start_i and stop_i together -> neither err_o nor busy_o.
REQ-032 SHALL cover abort: stop_i asserted while phase_inc_o=110 in the REQ-028 config -> IDLE next edge, phase_inc_o=110, no done_o; simultaneous stop_i and step edge -> word not advanced.
REQ-033 SHALL cover async reset: rst_i pulsed mid-dwell between clock edges -> all outputs 0 before the next edge; a new start right after release behaves as in REQ-028.

Source files
------------

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer for a DDS: steps the phase increment from a start
// word to a stop word, holding each word for a programmable dwell time.
module dds_sweep_ctrl #(
  parameter int PHASE_INC_WIDTH = 16,
  parameter int DWELL_WIDTH     = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic                       stop_i,
  input  logic                       mode_i,
  input  logic [PHASE_INC_WIDTH-1:0] f_start_i,
  input  logic [PHASE_INC_WIDTH-1:0] f_stop_i,
  input  logic [PHASE_INC_WIDTH-1:0] f_step_i,
  input  logic [DWELL_WIDTH-1:0]     dwell_i,
  output logic [PHASE_INC_WIDTH-1:0] phase_inc_o,
  output logic                       phase_inc_ena_o,
  output logic                       update_o,
  output logic                       done_o,
  output logic                       err_o,
  output logic                       busy_o
);

  typedef enum logic {IDLE, DWELL} state_t;

  state_t                     state_q, state_d;
  logic [DWELL_WIDTH-1:0]     cnt_q, cnt_d;
  logic [DWELL_WIDTH-1:0]     dwell_q, dwell_d;
  logic [PHASE_INC_WIDTH-1:0] start_q, start_d;
  logic [PHASE_INC_WIDTH-1:0] stop_q, stop_d;
  logic [PHASE_INC_WIDTH-1:0] step_q, step_d;
  logic                       mode_q, mode_d;
  logic [PHASE_INC_WIDTH-1:0] phase_inc_d;
  logic                       ena_d, busy_d, update_d, done_d, err_d;
  logic [PHASE_INC_WIDTH:0]   next_word;

  // Extra MSB keeps the carry so an overflowing step is never taken as a small word.
  function automatic logic [PHASE_INC_WIDTH:0] step_word(
    input logic [PHASE_INC_WIDTH-1:0] cur,
    input logic [PHASE_INC_WIDTH-1:0] inc
  );
    return {1'b0, cur} + {1'b0, inc};
  endfunction

  assign next_word = step_word(phase_inc_o, step_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dwell_d     = dwell_q;
    start_d     = start_q;
    stop_d      = stop_q;
    step_d      = step_q;
    mode_d      = mode_q;
    phase_inc_d = phase_inc_o;
    ena_d       = phase_inc_ena_o;
    busy_d      = busy_o;
    update_d    = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i && !stop_i) begin
          if (f_step_i == '0 || f_start_i > f_stop_i) begin
            err_d = 1'b1;
          end else begin
            start_d     = f_start_i;
            stop_d      = f_stop_i;
            step_d      = f_step_i;
            dwell_d     = dwell_i;
            mode_d      = mode_i;
            phase_inc_d = f_start_i;
            cnt_d       = dwell_i;
            update_d    = 1'b1;
            ena_d       = 1'b1;
            busy_d      = 1'b1;
            state_d     = DWELL;
          end
        end
      end
      DWELL: begin
        if (stop_i) begin
          ena_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_WIDTH'(1);
        end else if (!next_word[PHASE_INC_WIDTH] &&
                     next_word[PHASE_INC_WIDTH-1:0] <= stop_q) begin
          phase_inc_d = next_word[PHASE_INC_WIDTH-1:0];
          update_d    = 1'b1;
          cnt_d       = dwell_q;
        end else if (mode_q) begin
          phase_inc_d = start_q;
          update_d    = 1'b1;
          cnt_d       = dwell_q;
        end else begin
          done_d  = 1'b1;
          ena_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      dwell_q         <= '0;
      start_q         <= '0;
      stop_q          <= '0;
      step_q          <= '0;
      mode_q          <= 1'b0;
      phase_inc_o     <= '0;
      phase_inc_ena_o <= 1'b0;
      busy_o          <= 1'b0;
      update_o        <= 1'b0;
      done_o          <= 1'b0;
      err_o           <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      dwell_q         <= dwell_d;
      start_q         <= start_d;
      stop_q          <= stop_d;
      step_q          <= step_d;
      mode_q          <= mode_d;
      phase_inc_o     <= phase_inc_d;
      phase_inc_ena_o <= ena_d;
      busy_o          <= busy_d;
      update_o        <= update_d;
      done_o          <= done_d;
      err_o           <= err_d;
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: stimulus pushes hand-computed pulse events into a
// queue, a negedge monitor pops and compares whenever the DUT emits a pulse.
module tb_dds_sweep_ctrl;

  localparam logic [2:0] UPD  = 3'b100;
  localparam logic [2:0] DONE = 3'b010;
  localparam logic [2:0] ERR  = 3'b001;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic        stop_i = 1'b0;
  logic        mode_i = 1'b0;
  logic [15:0] f_start_i = '0;
  logic [15:0] f_stop_i = '0;
  logic [15:0] f_step_i = '0;
  logic [15:0] dwell_i = '0;
  logic [15:0] phase_inc_o;
  logic        phase_inc_ena_o, update_o, done_o, err_o, busy_o;

  typedef struct {
    logic [2:0]  pulses;
    int          cyc;
    logic [15:0] word;
    logic        act;
  } ev_t;

  ev_t q[$];
  int  cyc = 0;
  int  errors = 0;
  int  checks = 0;
  int  ena_cycles = 0;
  int  n;

  dds_sweep_ctrl #(.PHASE_INC_WIDTH(16), .DWELL_WIDTH(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
    .mode_i(mode_i), .f_start_i(f_start_i), .f_stop_i(f_stop_i),
    .f_step_i(f_step_i), .dwell_i(dwell_i), .phase_inc_o(phase_inc_o),
    .phase_inc_ena_o(phase_inc_ena_o), .update_o(update_o), .done_o(done_o),
    .err_o(err_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, queue=%0d", q.size());
    $fatal(1, "timeout");
  end

  // Monitor: every pulse must match the head of the expectation queue.
  always @(negedge clk_i) begin
    if (phase_inc_ena_o) ena_cycles = ena_cycles + 1;
    if (update_o || done_o || err_o) begin
      checks = checks + 1;
      if (q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_event: got pulses=%b cyc=%0d word=%h, required no event",
                 {update_o, done_o, err_o}, cyc, phase_inc_o);
      end else begin
        ev_t e;
        e = q.pop_front();
        if ({update_o, done_o, err_o} != e.pulses || cyc != e.cyc || phase_inc_o != e.word ||
            phase_inc_ena_o != e.act || busy_o != e.act) begin
          errors = errors + 1;
          $display("FAIL event: got pulses=%b cyc=%0d word=%h ena=%b busy=%b, required pulses=%b cyc=%0d word=%h ena/busy=%b",
                   {update_o, done_o, err_o}, cyc, phase_inc_o, phase_inc_ena_o, busy_o,
                   e.pulses, e.cyc, e.word, e.act);
        end
      end
    end
  end

  task automatic push(input logic [2:0] p, input int c, input logic [15:0] w, input logic a);
    ev_t e;
    e.pulses = p; e.cyc = c; e.word = w; e.act = a;
    q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks = checks + 1;
    if (got !== req) begin
      errors = errors + 1;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // Called at a negedge: drives a start so that the next rising edge is edge n.
  task automatic set_start(input logic [15:0] fs, input logic [15:0] fe, input logic [15:0] st,
                           input logic [15:0] dw, input logic md, output int edge_n);
    f_start_i = fs; f_stop_i = fe; f_step_i = st; dwell_i = dw; mode_i = md;
    start_i = 1'b1;
    edge_n = cyc + 1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk_i);
  endtask

  task automatic push_single_028(input int base);
    push(UPD, base,      16'd100, 1'b1);
    push(UPD, base + 3,  16'd110, 1'b1);
    push(UPD, base + 6,  16'd120, 1'b1);
    push(UPD, base + 9,  16'd130, 1'b1);
    push(DONE, base + 12, 16'd130, 1'b0);
  endtask

  initial begin
    logic [15:0] words [4];
    words[0] = 16'd100; words[1] = 16'd110; words[2] = 16'd120; words[3] = 16'd130;

    // Reset applied with no clock edge yet.
    #1 rst_i = 1'b1;
    #1 check("reset_outputs", {8'h0, phase_inc_o, phase_inc_ena_o, update_o, done_o, err_o, busy_o, 3'b0}, 32'h0);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Single sweep 100..130 step 10, dwell 2.
    ena_cycles = 0;
    set_start(16'd100, 16'd130, 16'd10, 16'd2, 1'b0, n);
    push_single_028(n);
    @(negedge clk_i); start_i = 1'b0;
    f_start_i = 16'd7; f_stop_i = 16'd9; f_step_i = 16'd1; dwell_i = 16'd0; mode_i = 1'b1;
    wait_until(n + 14);
    check("single_ena_cycles", ena_cycles, 32'd12);
    check("single_final_word", phase_inc_o, 32'd130);
    check("single_idle_busy", {phase_inc_ena_o, busy_o}, 32'd0);

    // Continuous mode: three periods, then stop before the next wrap.
    set_start(16'd100, 16'd130, 16'd10, 16'd2, 1'b1, n);
    for (int k = 0; k < 12; k++) push(UPD, n + 3 * k, words[k % 4], 1'b1);
    @(negedge clk_i); start_i = 1'b0;
    wait_until(n + 34);
    stop_i = 1'b1;
    @(negedge clk_i); stop_i = 1'b0;
    check("cont_stop_word", phase_inc_o, 32'd130);
    check("cont_stop_idle", {phase_inc_ena_o, busy_o}, 32'd0);
    repeat (4) @(negedge clk_i);

    // Carry-out: 0xFFF0 + 0x10 overflows, so the sweep ends after one word.
    set_start(16'hFFF0, 16'hFFFF, 16'h0010, 16'd0, 1'b0, n);
    push(UPD, n, 16'hFFF0, 1'b1);
    push(DONE, n + 1, 16'hFFF0, 1'b0);
    @(negedge clk_i); start_i = 1'b0;
    wait_until(n + 3);
    check("carry_word_held", phase_inc_o, 32'hFFF0);

    // Rejected starts and start+stop together.
    set_start(16'd10, 16'd20, 16'd0, 16'd1, 1'b0, n);
    push(ERR, n, 16'hFFF0, 1'b0);
    @(negedge clk_i); start_i = 1'b0;
    @(negedge clk_i);
    check("reject_step0_busy", busy_o, 32'd0);
    set_start(16'd200, 16'd100, 16'd5, 16'd1, 1'b0, n);
    push(ERR, n, 16'hFFF0, 1'b0);
    @(negedge clk_i); start_i = 1'b0;
    @(negedge clk_i);
    check("reject_order_busy", busy_o, 32'd0);
    set_start(16'd100, 16'd130, 16'd10, 16'd2, 1'b0, n);
    stop_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0; stop_i = 1'b0;
    @(negedge clk_i);
    check("start_stop_idle", {phase_inc_ena_o, busy_o, phase_inc_o}, 32'h0000FFF0);

    // Abort while holding 110.
    set_start(16'd100, 16'd130, 16'd10, 16'd2, 1'b0, n);
    push(UPD, n, 16'd100, 1'b1);
    push(UPD, n + 3, 16'd110, 1'b1);
    @(negedge clk_i); start_i = 1'b0;
    wait_until(n + 3);
    stop_i = 1'b1;
    @(negedge clk_i); stop_i = 1'b0;
    check("abort_word", phase_inc_o, 32'd110);
    check("abort_idle", {phase_inc_ena_o, busy_o}, 32'd0);
    repeat (3) @(negedge clk_i);

    // Stop on the very edge that would have stepped to 110.
    set_start(16'd100, 16'd130, 16'd10, 16'd2, 1'b0, n);
    push(UPD, n, 16'd100, 1'b1);
    @(negedge clk_i); start_i = 1'b0;
    wait_until(n + 2);
    stop_i = 1'b1;
    @(negedge clk_i); stop_i = 1'b0;
    check("stop_on_step_word", phase_inc_o, 32'd100);
    check("stop_on_step_idle", {phase_inc_ena_o, busy_o}, 32'd0);
    repeat (3) @(negedge clk_i);

    // Asynchronous reset mid-dwell, then restart on the first edge after release.
    set_start(16'd100, 16'd130, 16'd10, 16'd2, 1'b0, n);
    push(UPD, n, 16'd100, 1'b1);
    push(UPD, n + 3, 16'd110, 1'b1);
    @(negedge clk_i); start_i = 1'b0;
    wait_until(n + 4);
    #2 rst_i = 1'b1;
    #1 check("async_reset_outputs", {8'h0, phase_inc_o, phase_inc_ena_o, update_o, done_o, err_o, busy_o, 3'b0}, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    ena_cycles = 0;
    set_start(16'd100, 16'd130, 16'd10, 16'd2, 1'b0, n);
    push_single_028(n);
    @(negedge clk_i); start_i = 1'b0;
    wait_until(n + 14);
    check("restart_ena_cycles", ena_cycles, 32'd12);
    check("restart_final_word", phase_inc_o, 32'd130);

    check("events_outstanding", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
